// File: rtl/pipe_stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: PC-source codes and fetch FSM states.
package pipe_stage_if_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    typedef enum logic {
        StRun  = 1'b0,
        StPend = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/mux4x32.sv
// Generic 4:1 multiplexer, 32 bits wide.
module mux4x32 (
    input  logic [31:0] a0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] a2_i,
    input  logic [31:0] a3_i,
    input  logic [1:0]  sel_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = a0_i;
        unique case (sel_i)
            2'b00:   y_o = a0_i;
            2'b01:   y_o = a1_i;
            2'b10:   y_o = a2_i;
            2'b11:   y_o = a3_i;
            default: y_o = a0_i;
        endcase
    end

endmodule

// File: rtl/pipe_stage_if_pc_next_mux.sv
// Next-PC selection on pcsource: sequential, branch, register (jr) or jump target.
module pipe_stage_if_pc_next_mux
    import pipe_stage_if_pkg::*;
(
    input  logic [31:0] pc_plus_4_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] jump_target_i,
    input  logic [1:0]  pcsource_i,
    output logic [31:0] next_pc_o
);

    mux4x32 u_mux (
        .a0_i  (pc_plus_4_i),
        .a1_i  (branch_target_i),
        .a2_i  (jr_target_i),
        .a3_i  (jump_target_i),
        .sel_i (pcsource_i),
        .y_o   (next_pc_o)
    );

endmodule

// File: rtl/pipe_stage_if.sv
// Instruction-fetch stage with IF/ID register; latches a redirect that arrives while the
// delay-slot fetch is still waiting on instruction memory.
module pipe_stage_if
    import pipe_stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] ID_pc_plus_4,
    output logic [31:0] inst_stored,
    output logic        ID_valid,
    output logic        redirect_pend
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic [31:0]  id_pc4_q, id_pc4_d;
    logic [31:0]  inst_q, inst_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus_4;
    logic [31:0]  next_pc;

    assign pc_plus_4 = pc_inc(pc_q);

    pipe_stage_if_pc_next_mux u_pc_next_mux (
        .pc_plus_4_i     (pc_plus_4),
        .branch_target_i (branch_target),
        .jr_target_i     (jr_target),
        .jump_target_i   (jump_target),
        .pcsource_i      (pcsource),
        .next_pc_o       (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        id_pc4_d   = id_pc4_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        if (wpcir) begin
            id_pc4_d = pc_plus_4;
            if (!imem_ready) begin
                // Delay slot not fetched yet: bubble into ID, park any redirect until it arrives.
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                if (pcsource != PCSRC_SEQ) begin
                    pend_tgt_d = next_pc;
                    state_d    = StPend;
                end
            end else begin
                inst_d  = imem_rdata;
                valid_d = 1'b1;
                if (state_q == StPend) begin
                    pc_d    = pend_tgt_q;
                    state_d = StRun;
                end else begin
                    pc_d = next_pc;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            pend_tgt_q <= RESET_PC;
            id_pc4_q   <= pc_inc(RESET_PC);
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            id_pc4_q   <= id_pc4_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ID_pc_plus_4  = id_pc4_q;
    assign inst_stored   = inst_q;
    assign ID_valid      = valid_q;
    assign redirect_pend = (state_q == StPend);

endmodule

// File: tb/tb_pipe_stage_if.sv
// Directed bench for pipe_stage_if; instruction memory returns 32'hC0DE_0000 | addr[15:0].
module tb_pipe_stage_if;

    logic        clock;
    logic        resetn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] ID_pc_plus_4;
    logic [31:0] inst_stored;
    logic        ID_valid;
    logic        redirect_pend;

    int compared;
    int mismatched;

    pipe_stage_if dut (
        .clock         (clock),
        .resetn        (resetn),
        .wpcir         (wpcir),
        .pcsource      (pcsource),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .ID_pc_plus_4  (ID_pc_plus_4),
        .inst_stored   (inst_stored),
        .ID_valid      (ID_valid),
        .redirect_pend (redirect_pend)
    );

    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ID holds a bubble while a redirect is pending, so no redirect request may appear then.
    always @(negedge clock) begin
        if (resetn && redirect_pend && pcsource != 2'b00) begin
            mismatched++;
            $display("FAIL pend_pcsource: pcsource=%b while redirect_pend, required 00", pcsource);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        wpcir = 1'b1; imem_ready = 1'b1; pcsource = 2'b00;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
    endtask

    task automatic goto_pc8();
        do_reset();
        tick();
        tick();
    endtask

    task automatic test_reset();
        compared++; if (imem_addr !== 32'h0) begin mismatched++;
            $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h0); end
        compared++; if (ID_pc_plus_4 !== 32'h4) begin mismatched++;
            $display("FAIL rst_pc4: got %h want %h", ID_pc_plus_4, 32'h4); end
        compared++; if (inst_stored !== 32'h0) begin mismatched++;
            $display("FAIL rst_inst: got %h want %h", inst_stored, 32'h0); end
        compared++; if (ID_valid !== 1'b0) begin mismatched++;
            $display("FAIL rst_valid: got %b want 0", ID_valid); end
        compared++; if (redirect_pend !== 1'b0) begin mismatched++;
            $display("FAIL rst_pend: got %b want 0", redirect_pend); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        compared++; if (imem_addr !== 32'h0) begin mismatched++;
            $display("FAIL seq_addr0: got %h want %h", imem_addr, 32'h0); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp = 32'(4 * i);
            compared++; if (imem_addr !== exp) begin mismatched++;
                $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, exp); end
            compared++; if (ID_pc_plus_4 !== exp) begin mismatched++;
                $display("FAIL seq_pc4_%0d: got %h want %h", i, ID_pc_plus_4, exp); end
            compared++; if (inst_stored !== (32'hC0DE_0000 | (exp - 32'd4))) begin mismatched++;
                $display("FAIL seq_inst%0d: got %h want %h", i, inst_stored,
                         32'hC0DE_0000 | (exp - 32'd4)); end
            compared++; if (ID_valid !== 1'b1) begin mismatched++;
                $display("FAIL seq_valid%0d: got %b want 1", i, ID_valid); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] tgt [3];
        tgt[0] = 32'h40; tgt[1] = 32'h80; tgt[2] = 32'h100;
        for (int k = 0; k < 3; k++) begin
            goto_pc8();
            branch_target = 32'h40; jr_target = 32'h80; jump_target = 32'h100;
            pcsource = 2'(k + 1);
            tick();
            pcsource = 2'b00;
            compared++; if (inst_stored !== 32'hC0DE_0008) begin mismatched++;
                $display("FAIL br%0d_inst: got %h want %h", k, inst_stored, 32'hC0DE_0008); end
            compared++; if (ID_pc_plus_4 !== 32'hC) begin mismatched++;
                $display("FAIL br%0d_pc4: got %h want %h", k, ID_pc_plus_4, 32'hC); end
            compared++; if (imem_addr !== tgt[k]) begin mismatched++;
                $display("FAIL br%0d_addr: got %h want %h", k, imem_addr, tgt[k]); end
        end
    endtask

    task automatic test_stall();
        goto_pc8();
        tick();
        wpcir = 1'b0; pcsource = 2'b11; jump_target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i != 1);
            tick();
            compared++; if (imem_addr !== 32'hC) begin mismatched++;
                $display("FAIL stall_addr%0d: got %h want %h", i, imem_addr, 32'hC); end
            compared++; if (inst_stored !== 32'hC0DE_0008) begin mismatched++;
                $display("FAIL stall_inst%0d: got %h want %h", i, inst_stored, 32'hC0DE_0008); end
            compared++; if (ID_pc_plus_4 !== 32'hC) begin mismatched++;
                $display("FAIL stall_pc4_%0d: got %h want %h", i, ID_pc_plus_4, 32'hC); end
            compared++; if (redirect_pend !== 1'b0) begin mismatched++;
                $display("FAIL stall_pend%0d: got %b want 0", i, redirect_pend); end
        end
        wpcir = 1'b1; pcsource = 2'b00; imem_ready = 1'b1;
        tick();
        compared++; if (imem_addr !== 32'h10) begin mismatched++;
            $display("FAIL stall_resume_addr: got %h want %h", imem_addr, 32'h10); end
        compared++; if (inst_stored !== 32'hC0DE_000C) begin mismatched++;
            $display("FAIL stall_resume_inst: got %h want %h", inst_stored, 32'hC0DE_000C); end
    endtask

    task automatic test_wait_redirect();
        goto_pc8();
        imem_ready = 1'b0; pcsource = 2'b11; jump_target = 32'h200;
        tick();
        pcsource = 2'b00;
        compared++; if (ID_valid !== 1'b0) begin mismatched++;
            $display("FAIL wait_valid: got %b want 0", ID_valid); end
        compared++; if (redirect_pend !== 1'b1) begin mismatched++;
            $display("FAIL wait_pend: got %b want 1", redirect_pend); end
        compared++; if (inst_stored !== 32'h0) begin mismatched++;
            $display("FAIL wait_inst: got %h want %h", inst_stored, 32'h0); end
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++; if (imem_addr !== 32'h8) begin mismatched++;
                $display("FAIL wait_addr%0d: got %h want %h", i, imem_addr, 32'h8); end
            compared++; if (redirect_pend !== 1'b1) begin mismatched++;
                $display("FAIL wait_pend%0d: got %b want 1", i, redirect_pend); end
        end
        imem_ready = 1'b1;
        tick();
        compared++; if (inst_stored !== 32'hC0DE_0008) begin mismatched++;
            $display("FAIL wait_done_inst: got %h want %h", inst_stored, 32'hC0DE_0008); end
        compared++; if (ID_valid !== 1'b1) begin mismatched++;
            $display("FAIL wait_done_valid: got %b want 1", ID_valid); end
        compared++; if (imem_addr !== 32'h200) begin mismatched++;
            $display("FAIL wait_done_addr: got %h want %h", imem_addr, 32'h200); end
        compared++; if (redirect_pend !== 1'b0) begin mismatched++;
            $display("FAIL wait_done_pend: got %b want 0", redirect_pend); end
    endtask

    task automatic test_stall_not_ready();
        goto_pc8();
        wpcir = 1'b0; imem_ready = 1'b0;
        tick();
        tick();
        compared++; if (inst_stored !== 32'hC0DE_0004) begin mismatched++;
            $display("FAIL snr_inst: got %h want %h", inst_stored, 32'hC0DE_0004); end
        compared++; if (ID_valid !== 1'b1) begin mismatched++;
            $display("FAIL snr_valid: got %b want 1", ID_valid); end
        compared++; if (imem_addr !== 32'h8) begin mismatched++;
            $display("FAIL snr_addr: got %h want %h", imem_addr, 32'h8); end
        wpcir = 1'b1; imem_ready = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        goto_pc8();
        imem_ready = 1'b0; pcsource = 2'b11; jump_target = 32'h200;
        tick();
        pcsource = 2'b00;
        compared++; if (redirect_pend !== 1'b1) begin mismatched++;
            $display("FAIL rmw_pend_before: got %b want 1", redirect_pend); end
        #2;
        resetn = 1'b0;
        #1;
        test_reset();
        #1;
        resetn = 1'b1;
        imem_ready = 1'b1;
        tick();
        compared++; if (imem_addr !== 32'h4) begin mismatched++;
            $display("FAIL rmw_after_addr: got %h want %h", imem_addr, 32'h4); end
    endtask

    task automatic test_wrap();
        goto_pc8();
        pcsource = 2'b11; jump_target = 32'hFFFF_FFFC;
        tick();
        pcsource = 2'b00;
        compared++; if (imem_addr !== 32'hFFFF_FFFC) begin mismatched++;
            $display("FAIL wrap_addr0: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        tick();
        compared++; if (imem_addr !== 32'h0) begin mismatched++;
            $display("FAIL wrap_addr1: got %h want %h", imem_addr, 32'h0); end
        compared++; if (ID_pc_plus_4 !== 32'h0) begin mismatched++;
            $display("FAIL wrap_pc4: got %h want %h", ID_pc_plus_4, 32'h0); end
        compared++; if (inst_stored !== 32'hC0DE_FFFC) begin mismatched++;
            $display("FAIL wrap_inst: got %h want %h", inst_stored, 32'hC0DE_FFFC); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        resetn = 1'b0;
        wpcir = 1'b1;
        pcsource = 2'b00;
        imem_ready = 1'b1;
        branch_target = 32'h0;
        jr_target = 32'h0;
        jump_target = 32'h0;
        #12;
        test_reset();
        resetn = 1'b1;
        test_sequential();
        test_branch();
        test_stall();
        test_wait_redirect();
        test_stall_not_ready();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
